// File: rtl/ahb_multi_timer_if.sv
// rtl/ahb_multi_timer_if.sv - AHB-lite slave bus bundle for the multi-channel timer
interface ahb_multi_timer_if;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic        HREADY;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADYOUT;

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HREADY, HWDATA,
        input  HRDATA, HREADYOUT
    );

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HREADY, HWDATA,
        output HRDATA, HREADYOUT
    );
endinterface

// File: rtl/ahb_multi_timer.sv
// rtl/ahb_multi_timer.sv - AHB-lite multi-channel up/down timer with shared prescaler
module ahb_multi_timer #(
    parameter int NUM_CH = 2,
    parameter int CNT_W  = 32,
    parameter int PRE_W  = 8
) (
    input  logic                HCLK,
    input  logic                HRESETn,
    ahb_multi_timer_if.slave    bus,
    output logic [NUM_CH-1:0]   timer_irq,
    output logic                timer_irq_any
);

    localparam logic [5:0] PRE_WORD = 6'h3C;  // byte offset 0xF0

    logic              r_dp_valid;
    logic              r_dp_write;
    logic [5:0]        r_dp_addr;   // HADDR[7:2] of the pending data phase
    logic [PRE_W-1:0]  r_prescale;
    logic [PRE_W-1:0]  r_pre_cnt;
    logic [CNT_W-1:0]  r_load  [NUM_CH];
    logic [CNT_W-1:0]  r_value [NUM_CH];
    logic [4:0]        r_ctrl  [NUM_CH];
    logic [NUM_CH-1:0] r_status;

    logic              w_accept;
    logic              w_wr;
    logic              w_pre_wr;
    logic              w_tick;
    logic [NUM_CH-1:0] w_ch_hit;
    logic [NUM_CH-1:0] w_step;
    logic [NUM_CH-1:0] w_term;
    logic [NUM_CH-1:0] w_set;
    logic [NUM_CH-1:0] w_clr;
    logic [CNT_W-1:0]  w_next [NUM_CH];
    logic [31:0]       w_rdata;
    logic              w_unused;

    assign w_accept = bus.HSEL & bus.HREADY & bus.HTRANS[1];
    assign w_wr     = r_dp_valid & r_dp_write;
    assign w_pre_wr = w_wr & (r_dp_addr == PRE_WORD);
    assign w_tick   = (r_pre_cnt == r_prescale);
    assign w_unused = ^{bus.HADDR[31:8], bus.HADDR[1:0], bus.HTRANS[0], bus.HWDATA};

    always_comb begin
        w_ch_hit = '0;
        w_step   = '0;
        w_term   = '0;
        w_set    = '0;
        w_clr    = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_ch_hit[i] = r_dp_valid && (r_dp_addr[5:2] == 4'(i));
            w_step[i]   = r_ctrl[i][0] & (r_ctrl[i][3] ? w_tick : 1'b1);
            // Up mode only terminates on exact equality, so VALUE > LOAD wraps silently.
            if (r_ctrl[i][1]) begin
                w_term[i] = (r_value[i] == r_load[i]);
                w_next[i] = w_term[i] ? '0 : r_value[i] + CNT_W'(1);
            end else begin
                w_term[i] = (r_value[i] == '0);
                w_next[i] = w_term[i] ? r_load[i] : r_value[i] - CNT_W'(1);
            end
            w_set[i] = w_step[i] & w_term[i];
            w_clr[i] = w_wr & w_ch_hit[i] & (r_dp_addr[1:0] == 2'd3) & bus.HWDATA[0];
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_dp_valid <= 1'b0;
            r_dp_write <= 1'b0;
            r_dp_addr  <= '0;
            r_prescale <= '0;
            r_pre_cnt  <= '0;
            r_status   <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                r_load[i]  <= '1;
                r_value[i] <= '0;
                r_ctrl[i]  <= '0;
            end
        end else begin
            r_dp_valid <= w_accept;
            if (w_accept) begin
                r_dp_write <= bus.HWRITE;
                r_dp_addr  <= bus.HADDR[7:2];
            end
            if (w_pre_wr) begin
                r_prescale <= bus.HWDATA[PRE_W-1:0];
                r_pre_cnt  <= '0;
            end else begin
                r_pre_cnt  <= w_tick ? '0 : r_pre_cnt + PRE_W'(1);
            end
            for (int i = 0; i < NUM_CH; i++) begin
                // One-shot terminal step holds VALUE and drops EN; bus writes below override.
                if (w_step[i]) begin
                    if (w_term[i] && !r_ctrl[i][2])
                        r_ctrl[i][0] <= 1'b0;
                    else
                        r_value[i] <= w_next[i];
                end
                if (w_wr && w_ch_hit[i]) begin
                    case (r_dp_addr[1:0])
                        2'd0:    r_load[i]  <= bus.HWDATA[CNT_W-1:0];
                        2'd1:    r_value[i] <= bus.HWDATA[CNT_W-1:0];
                        2'd2:    r_ctrl[i]  <= bus.HWDATA[4:0];
                        default: ;
                    endcase
                end
                r_status[i] <= w_set[i] | (r_status[i] & ~w_clr[i]);
            end
        end
    end

    always_comb begin
        w_rdata = '0;
        if (r_dp_valid && !r_dp_write) begin
            if (r_dp_addr == PRE_WORD)
                w_rdata = 32'(r_prescale);
            for (int i = 0; i < NUM_CH; i++) begin
                if (w_ch_hit[i]) begin
                    case (r_dp_addr[1:0])
                        2'd0:    w_rdata = 32'(r_load[i]);
                        2'd1:    w_rdata = 32'(r_value[i]);
                        2'd2:    w_rdata = 32'(r_ctrl[i]);
                        default: w_rdata = 32'(r_status[i]);
                    endcase
                end
            end
        end
    end

    always_comb begin
        timer_irq = '0;
        for (int i = 0; i < NUM_CH; i++)
            timer_irq[i] = r_status[i] & r_ctrl[i][4];
    end

    assign timer_irq_any  = |timer_irq;
    assign bus.HRDATA     = w_rdata;
    assign bus.HREADYOUT  = 1'b1;

endmodule

// File: doc/ahb_multi_timer.md
AHB_MULTI_TIMER -- requirements
Module: ahb_multi_timer

Interface
REQ-001 Parameter NUM_CH, default 2: number of independent timer channels, legal 1..8.
REQ-002 Parameter CNT_W, default 32: counter and LOAD width, legal 8..32.
REQ-003 Parameter PRE_W, default 8: shared prescaler divisor width, legal 1..16.
REQ-004 HCLK input 1: single clock; all state changes on its rising edge.
REQ-005 HRESETn input 1: asynchronous, active-low reset.
REQ-006 HSEL input 1: slave select.
REQ-007 HADDR input 32: byte address; only HADDR[7:0] decoded.
REQ-008 HTRANS input 2: transfer type; HTRANS[1]=1 marks NONSEQ/SEQ.
REQ-009 HWRITE input 1: 1 = write transfer.
REQ-010 HREADY input 1: bus ready; the address phase is accepted only when high.
REQ-011 HWDATA input 32: write data, valid in the data phase.
REQ-012 HRDATA output 32: read data, valid in the data phase.
REQ-013 HREADYOUT output 1: tied to 1 (zero wait states).
REQ-014 timer_irq output NUM_CH: per-channel interrupt.
REQ-015 timer_irq_any output 1: OR of timer_irq.

Function
REQ-016 Register map, channel n at offset n*0x10: LOAD +0x0 (RW), VALUE +0x4 (RW), CTRL +0x8 (RW, bits[4:0]), STATUS +0xC (bit0 W1C); PRESCALE at 0xF0 (RW, PRE_W bits).
REQ-017 CTRL bits: [0] EN; [1] DIR (1 = up); [2] PERIODIC (0 = one-shot); [3] PRE_EN; [4] IRQ_EN.
REQ-018 Address phase accepted when HSEL & HREADY & HTRANS[1]: register HADDR[7:0] and HWRITE, set data-phase valid flag; otherwise clear the flag.
REQ-019 Data-phase write: HWDATA written into the addressed register at the end of the data-phase cycle.
REQ-020 Data-phase read: HRDATA = addressed register, zero-extended; unmapped offsets and channels >= NUM_CH read 0, and writes to them are ignored.
REQ-021 Prescaler: free-running counter 0..PRESCALE; tick asserted for one HCLK when it equals PRESCALE, then wraps to 0; PRESCALE=0 gives a tick every cycle.
REQ-022 Prescaler counter cleared in the cycle PRESCALE is written.
REQ-023 Channel step enable = EN & (PRE_EN ? tick : 1).
REQ-024 Up mode step: if VALUE == LOAD, set STATUS and VALUE <= 0; otherwise VALUE <= VALUE + 1.
REQ-025 Down mode step: if VALUE == 0, set STATUS and VALUE <= LOAD; otherwise VALUE <= VALUE - 1.
REQ-026 In up mode, VALUE > LOAD (after a DIR or LOAD change) counts up and wraps modulo 2^CNT_W to 0 without setting STATUS, then proceeds normally.
REQ-027 One-shot: on the terminal step, STATUS is set, EN cleared, and VALUE holds the terminal value (LOAD if up, 0 if down).
REQ-028 timer_irq[n] = STATUS[n] & IRQ_EN[n], combinational from registers.
REQ-029 A bus write to VALUE in the same cycle as a step wins; the step is discarded.
REQ-030 A bus write to CTRL in the same cycle as a one-shot terminal step: the written EN value wins.
REQ-031 STATUS set and a W1C clear in the same cycle: the set wins, STATUS stays 1.
REQ-032 Writing 0 to a STATUS bit has no effect; CTRL bits [31:5] are ignored on write and read 0.

Reset
REQ-033 HRESETn low asynchronously forces: LOAD = all ones (CNT_W), VALUE = 0, CTRL = 0, STATUS = 0, PRESCALE = 0, prescaler counter = 0, data-phase flag = 0.
REQ-034 During reset, timer_irq = 0, timer_irq_any = 0, HRDATA = 0, HREADYOUT = 1.
REQ-035 Reset asserted mid-count or mid-transfer aborts the pending data-phase write and leaves no partial state.
REQ-036 Operation resumes on the first HCLK rising edge after HRESETn deasserts.

Verification
REQ-037 Ch0: LOAD=3, CTRL=0x17 (EN, up, periodic, IRQ_EN), no prescale -> VALUE sequence 0,1,2,3,0; STATUS and timer_irq[0] rise on the 3->0 step.
REQ-038 Ch1: LOAD=5, VALUE=2, CTRL=0x11 (down, one-shot) -> VALUE 2,1,0; STATUS set; EN reads 0; VALUE holds 0.
REQ-039 PRESCALE=3, ch0: CTRL=0x0B, LOAD=0xFF -> VALUE increments once per 4 HCLK.
REQ-040 STATUS set and W1C of 0x1 in the same cycle -> STATUS stays 1; a later W1C clears it and timer_irq drops.
REQ-041 Write VALUE=0x10 in a step cycle -> next read returns 0x10; read at 0x40 with NUM_CH=2 -> 0.
REQ-042 Assert HRESETn low mid-count -> all registers read reset values, and timer_irq = 0 immediately.
